spi_slave_phy: RTL and testbench



---
 rtl/spi_slave_phy.sv | 208 ++++++++++++++++++++
 tb/tb_spi_slave_phy.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_phy.sv
// rtl/spi_slave_phy.sv - SPI mode-0 slave front end: pin sync, MOSI deserializer, MISO serializer
module spi_slave_phy #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_TX     = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_clk_pin,
    input  logic       spi_cs_pin,
    input  logic       spi_mosi_pin,
    output logic       spi_miso_pin,
    output logic       spi_miso_oe,
    output logic       spi_cs,
    output logic [7:0] spi_rx_data,
    output logic [2:0] spi_rx_bit,
    output logic       spi_rx_bit_strobe,
    output logic       spi_rx_strobe,
    output logic       spi_rx_cmd,
    input  logic       spi_tx_strobe,
    input  logic [7:0] spi_tx_data,
    input  logic       spi_output_enable,
    output logic [7:0] frame_errors,
    output logic [7:0] tx_underruns
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;

    state_t     r_state;
    logic       r_armed;
    logic [2:0] r_bit_cnt;
    logic       r_first_byte;
    logic       r_tx_valid;
    logic [7:0] r_tx_buf;
    logic [7:0] r_tx_sr;
    logic       r_tx_fresh;
    logic       r_slot_underrun;
    logic [7:0] r_rx_sr;
    logic [2:0] r_rx_bit;
    logic       r_rx_bit_strobe;
    logic       r_rx_strobe;
    logic       r_rx_cmd;
    logic       r_spi_cs;
    logic       r_oe;
    logic [7:0] r_frame_errors;
    logic [7:0] r_tx_underruns;

    logic w_sclk;
    logic w_cs_n;
    logic w_mosi;
    logic w_rise;
    logic w_fall;

    // CS chain resets low so a pin held low across reset cannot arm the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk_pin};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_pin};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_pin};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~r_sclk_d;
    assign w_fall = ~w_sclk & r_sclk_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_armed         <= 1'b0;
            r_bit_cnt       <= 3'd0;
            r_first_byte    <= 1'b1;
            r_tx_valid      <= 1'b0;
            r_tx_buf        <= 8'h00;
            r_tx_sr         <= 8'hFF;
            r_tx_fresh      <= 1'b0;
            r_slot_underrun <= 1'b0;
            r_rx_sr         <= 8'h00;
            r_rx_bit        <= 3'd0;
            r_rx_bit_strobe <= 1'b0;
            r_rx_strobe     <= 1'b0;
            r_rx_cmd        <= 1'b0;
            r_spi_cs        <= 1'b1;
            r_oe            <= 1'b0;
            r_frame_errors  <= 8'd0;
            r_tx_underruns  <= 8'd0;
        end else begin
            r_rx_bit_strobe <= 1'b0;
            r_rx_strobe     <= 1'b0;
            r_rx_cmd        <= 1'b0;
            r_oe            <= (r_state == S_ACTIVE) && spi_output_enable;
            if (w_cs_n) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_spi_cs        <= 1'b1;
                    r_bit_cnt       <= 3'd0;
                    r_first_byte    <= 1'b1;
                    r_tx_fresh      <= 1'b0;
                    r_slot_underrun <= 1'b0;
                    if (spi_tx_strobe) begin
                        r_tx_buf   <= spi_tx_data;
                        r_tx_valid <= 1'b1;
                    end
                    if (!w_cs_n && r_armed) begin
                        r_state    <= S_ACTIVE;
                        r_spi_cs   <= 1'b0;
                        r_tx_fresh <= 1'b1;
                        r_tx_valid <= 1'b0;
                        if (spi_tx_strobe) begin
                            r_tx_sr <= spi_tx_data;
                        end else begin
                            r_tx_sr <= r_tx_valid ? r_tx_buf : IDLE_TX;
                        end
                    end
                end

                S_ACTIVE: begin
                    if (w_cs_n) begin
                        r_state      <= S_IDLE;
                        r_spi_cs     <= 1'b1;
                        r_tx_valid   <= 1'b0;
                        r_tx_fresh   <= 1'b0;
                        r_bit_cnt    <= 3'd0;
                        r_first_byte <= 1'b1;
                        if (r_bit_cnt != 3'd0 && r_frame_errors != 8'hFF) begin
                            r_frame_errors <= r_frame_errors + 8'd1;
                        end
                    end else begin
                        if (spi_tx_strobe) begin
                            r_tx_buf   <= spi_tx_data;
                            r_tx_valid <= 1'b1;
                        end
                        if (w_rise) begin
                            r_rx_sr         <= {r_rx_sr[6:0], w_mosi};
                            r_rx_bit        <= r_bit_cnt;
                            r_rx_bit_strobe <= 1'b1;
                            r_bit_cnt       <= r_bit_cnt + 3'd1;
                            r_tx_fresh      <= 1'b0;
                            r_slot_underrun <= 1'b0;
                            if (r_bit_cnt == 3'd7) begin
                                r_rx_strobe  <= 1'b1;
                                r_rx_cmd     <= r_first_byte;
                                r_first_byte <= 1'b0;
                            end
                        end else if (w_fall) begin
                            if (r_bit_cnt != 3'd0) begin
                                r_tx_sr <= {r_tx_sr[6:0], 1'b1};
                            end else begin
                                // Byte boundary: a coincident strobe bypasses the buffer.
                                r_tx_fresh      <= 1'b1;
                                r_tx_valid      <= 1'b0;
                                r_slot_underrun <= 1'b0;
                                if (spi_tx_strobe) begin
                                    r_tx_sr <= spi_tx_data;
                                end else if (r_tx_valid) begin
                                    r_tx_sr <= r_tx_buf;
                                end else begin
                                    r_tx_sr <= IDLE_TX;
                                    if (r_tx_underruns != 8'hFF) begin
                                        r_tx_underruns  <= r_tx_underruns + 8'd1;
                                        r_slot_underrun <= 1'b1;
                                    end
                                end
                            end
                        end else if (spi_tx_strobe && r_tx_fresh) begin
                            // Late load: the slot has not shifted yet, so replace it in place.
                            r_tx_sr    <= spi_tx_data;
                            r_tx_valid <= 1'b0;
                            if (r_slot_underrun) begin
                                r_tx_underruns  <= r_tx_underruns - 8'd1;
                                r_slot_underrun <= 1'b0;
                            end
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign spi_miso_pin      = r_tx_sr[7];
    assign spi_miso_oe       = r_oe;
    assign spi_cs            = r_spi_cs;
    assign spi_rx_data       = r_rx_sr;
    assign spi_rx_bit        = r_rx_bit;
    assign spi_rx_bit_strobe = r_rx_bit_strobe;
    assign spi_rx_strobe     = r_rx_strobe;
    assign spi_rx_cmd        = r_rx_cmd;
    assign frame_errors      = r_frame_errors;
    assign tx_underruns      = r_tx_underruns;

endmodule

// File: tb/tb_spi_slave_phy.sv
// tb/tb_spi_slave_phy.sv - directed bench for spi_slave_phy with a bit-level scoreboard
module tb_spi_slave_phy;

    localparam int HALF = 8;

    logic       clk;
    logic       reset_n;
    logic       spi_clk_pin;
    logic       spi_cs_pin;
    logic       spi_mosi_pin;
    logic       spi_miso_pin;
    logic       spi_miso_oe;
    logic       spi_cs;
    logic [7:0] spi_rx_data;
    logic [2:0] spi_rx_bit;
    logic       spi_rx_bit_strobe;
    logic       spi_rx_strobe;
    logic       spi_rx_cmd;
    logic       spi_tx_strobe;
    logic [7:0] spi_tx_data;
    logic       spi_output_enable;
    logic [7:0] frame_errors;
    logic [7:0] tx_underruns;

    spi_slave_phy #(.SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .spi_clk_pin       (spi_clk_pin),
        .spi_cs_pin        (spi_cs_pin),
        .spi_mosi_pin      (spi_mosi_pin),
        .spi_miso_pin      (spi_miso_pin),
        .spi_miso_oe       (spi_miso_oe),
        .spi_cs            (spi_cs),
        .spi_rx_data       (spi_rx_data),
        .spi_rx_bit        (spi_rx_bit),
        .spi_rx_bit_strobe (spi_rx_bit_strobe),
        .spi_rx_strobe     (spi_rx_strobe),
        .spi_rx_cmd        (spi_rx_cmd),
        .spi_tx_strobe     (spi_tx_strobe),
        .spi_tx_data       (spi_tx_data),
        .spi_output_enable (spi_output_enable),
        .frame_errors      (frame_errors),
        .tx_underruns      (tx_underruns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] data;
        logic       last;
        logic       cmd;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rx_log[$];
    logic       cmd_log[$];
    logic [7:0] last_b6;
    int         n_vec;
    int         n_fail;

    // Reference model: the last eight accepted MOSI bits, position in byte, first-byte flag.
    logic [7:0] m_hist;
    int         m_cnt;
    bit         m_first;
    int         m_ferr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_hist  = 8'h00;
        m_cnt   = 0;
        m_first = 1'b1;
        m_ferr  = 0;
        exp_q.delete();
    endtask

    task automatic model_bit(input logic b);
        exp_t e;
        m_hist = {m_hist[6:0], b};
        e.idx  = 3'(m_cnt);
        e.data = m_hist;
        e.last = (m_cnt == 7);
        e.cmd  = (m_cnt == 7) && m_first;
        exp_q.push_back(e);
        if (m_cnt == 7) m_first = 1'b0;
        m_cnt = (m_cnt + 1) % 8;
    endtask

    task automatic model_cs_rise();
        if (m_cnt != 0 && m_ferr < 255) m_ferr++;
        m_cnt   = 0;
        m_first = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (spi_rx_bit_strobe) begin
            if (spi_rx_bit == 3'd6) last_b6 = spi_rx_data;
            if (spi_rx_strobe) begin
                rx_log.push_back(spi_rx_data);
                cmd_log.push_back(spi_rx_cmd);
            end
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_bit_strobe: got bit %0d data %02h expected no strobe",
                         spi_rx_bit, spi_rx_data);
            end else begin
                e = exp_q.pop_front();
                chk("rx_bit", spi_rx_bit, e.idx);
                chk("rx_data", spi_rx_data, e.data);
                chk("rx_strobe", spi_rx_strobe, e.last);
                chk("rx_cmd", spi_rx_cmd, e.cmd);
            end
        end else if (spi_rx_strobe || spi_rx_cmd) begin
            n_vec++;
            n_fail++;
            $display("FAIL stray_byte_strobe: got strobe %0b cmd %0b expected 0 0",
                     spi_rx_strobe, spi_rx_cmd);
        end
    end

    task automatic xfer(input logic [7:0] mo, input int nbits, input int strobe_bit,
                        input logic [7:0] sval, input bit expect_rx,
                        output logic [7:0] mi, output logic [7:0] u_pre, output logic [7:0] u_mid);
        mi    = 8'h00;
        u_pre = 8'h00;
        u_mid = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            spi_mosi_pin = mo[7-b];
            if (expect_rx) model_bit(mo[7-b]);
            for (int c = 0; c < HALF; c++) begin
                if (b == 0 && c == 3) u_pre = tx_underruns;
                if (b == strobe_bit && c == 3) begin
                    spi_tx_strobe = 1'b1;
                    spi_tx_data   = sval;
                end
                @(negedge clk);
                spi_tx_strobe = 1'b0;
            end
            if (b == 0) u_mid = tx_underruns;
            mi[7-b]     = spi_miso_pin;
            spi_clk_pin = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_clk_pin = 1'b0;
        end
    endtask

    task automatic cs_high(input bit track);
        repeat (HALF) @(negedge clk);
        spi_cs_pin = 1'b1;
        if (track) model_cs_rise();
        repeat (HALF) @(negedge clk);
    endtask

    logic [7:0] mi, up, um;
    int         base;

    initial begin
        n_vec = 0;
        n_fail = 0;
        last_b6 = 8'h00;
        reset_n = 1'b0;
        spi_clk_pin = 1'b0;
        spi_cs_pin = 1'b1;
        spi_mosi_pin = 1'b0;
        spi_tx_strobe = 1'b0;
        spi_tx_data = 8'h00;
        spi_output_enable = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_spi_cs", spi_cs, 1'b1);
        chk("rst_miso", spi_miso_pin, 1'b1);
        chk("rst_oe", spi_miso_oe, 1'b0);
        chk("rst_strobes", {spi_rx_bit_strobe, spi_rx_strobe, spi_rx_cmd}, 3'b000);
        chk("rst_rx_data", spi_rx_data, 8'h00);
        chk("rst_rx_bit", spi_rx_bit, 3'd0);
        chk("rst_counters", {frame_errors, tx_underruns}, 16'h0000);
        reset_n = 1'b1;
        repeat (HALF) @(negedge clk);

        // Four-byte command with engine TX supplied one byte ahead.
        spi_output_enable = 1'b1;
        spi_cs_pin = 1'b0;
        xfer(8'h03, 8, 3, 8'hA5, 1'b1, mi, up, um);
        chk("miso_slot0", mi, 8'hFF);
        chk("oe_active", spi_miso_oe, 1'b1);
        chk("spi_cs_active", spi_cs, 1'b0);
        xfer(8'h12, 8, 3, 8'h3C, 1'b1, mi, up, um);
        chk("miso_A5", mi, 8'hA5);
        xfer(8'h34, 8, -1, 8'h00, 1'b1, mi, up, um);
        chk("miso_3C", mi, 8'h3C);
        chk("underruns_zero", up, 8'd0);
        xfer(8'h56, 8, -1, 8'h00, 1'b1, mi, up, um);
        chk("miso_idle", mi, 8'hFF);
        chk("underruns_one", up, 8'd1);
        chk("underruns_one_hold", um, 8'd1);
        chk("bit6_data", last_b6[6:0], 7'h2B);
        cs_high(1'b1);
        chk("missing_strobes_t1", exp_q.size(), 0);
        chk("rx_count_t1", rx_log.size(), 4);
        chk("rx_byte0", rx_log[0], 8'h03);
        chk("rx_byte1", rx_log[1], 8'h12);
        chk("rx_byte2", rx_log[2], 8'h34);
        chk("rx_byte3", rx_log[3], 8'h56);
        chk("cmd_flags_t1", {cmd_log[0], cmd_log[1], cmd_log[2], cmd_log[3]}, 4'b1000);
        chk("oe_idle", spi_miso_oe, 1'b0);
        chk("spi_cs_idle", spi_cs, 1'b1);

        // Partial byte then a clean command byte.
        spi_cs_pin = 1'b0;
        xfer(8'hE8, 5, -1, 8'h00, 1'b1, mi, up, um);
        cs_high(1'b1);
        chk("frame_errors_model", frame_errors, m_ferr);
        chk("frame_errors_one", frame_errors, 8'd1);
        chk("rx_count_partial", rx_log.size(), 4);
        spi_cs_pin = 1'b0;
        xfer(8'h9F, 8, -1, 8'h00, 1'b1, mi, up, um);
        cs_high(1'b1);
        chk("missing_strobes_t2", exp_q.size(), 0);
        chk("rx_byte_9F", rx_log[4], 8'h9F);
        chk("cmd_9F", cmd_log[4], 1'b1);

        // Reset in mid-byte with CS# held low.
        spi_cs_pin = 1'b0;
        xfer(8'h5A, 3, -1, 8'h00, 1'b1, mi, up, um);
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("mid_rst_counters", {frame_errors, tx_underruns}, 16'h0000);
        chk("mid_rst_cs_miso", {spi_cs, spi_miso_pin}, 2'b11);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        base = rx_log.size();
        xfer(8'hFF, 8, -1, 8'h00, 1'b0, mi, up, um);
        repeat (HALF) @(negedge clk);
        chk("unarmed_no_strobe", rx_log.size(), base);
        chk("unarmed_rx_data", spi_rx_data, 8'h00);
        cs_high(1'b1);
        spi_cs_pin = 1'b0;
        xfer(8'h05, 8, -1, 8'h00, 1'b1, mi, up, um);
        chk("miso_after_rst", mi, 8'hFF);
        xfer(8'hC3, 8, 0, 8'h81, 1'b1, mi, up, um);
        chk("late_underrun_pre", up, 8'd1);
        chk("late_underrun_retract", um, 8'd0);
        chk("miso_late_81", mi, 8'h81);
        cs_high(1'b1);
        chk("missing_strobes_t3", exp_q.size(), 0);
        chk("rx_count_t3", rx_log.size(), base + 2);
        chk("rx_byte_05", rx_log[base], 8'h05);
        chk("cmd_05", {cmd_log[base], cmd_log[base+1]}, 2'b10);
        chk("rx_byte_C3", rx_log[base+1], 8'hC3);
        chk("frame_errors_after_rst", frame_errors, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
